// File: rtl/dmem_responder.sv
// Data-memory responder for the multicycle core's data port: one load/store at a time,
// fixed-latency response that is held until the core takes it.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int READ_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [30:0] DEPTH_L = 31'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [31:0]   rdata_reg;
    logic          err_reg;
    logic          accept;
    logic          legal;
    logic [AW-1:0] word_idx;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept   = (state_reg == IDLE) && req_valid;
    assign legal    = (req_addr[1:0] == 2'b00) && ({1'b0, req_addr[31:2]} < DEPTH_L);
    assign word_idx = req_addr[AW+1:2];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic; the counter saturates at zero rather than wrapping
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    cnt_next   = CNT_INIT;
                    state_next = (READ_LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg <= 4'd1) begin
                    cnt_next   = 4'd0;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Handshake outputs are pure state decodes
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_reg)
            IDLE:    req_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Response payload is snapshotted at acceptance and held until the next request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else if (accept) begin
            rdata_reg <= (legal && !req_write) ? mem[word_idx] : 32'd0;
            err_reg   <= !legal;
        end
    end

    // Storage is never cleared by rst; illegal stores are dropped instead of aliased
    always_ff @(posedge clk) begin
        if (accept && req_write && legal && !rst) begin
            mem[word_idx] <= req_wdata;
        end
    end

    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at READ_LAT=2, one at READ_LAT=1.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid, req_write, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid1, req_write1, rsp_ready1;
    logic [31:0] req_addr1, req_wdata1;
    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;

    int n_checks;
    int n_fail;

    dmem_responder #(.DEPTH_WORDS(64), .READ_LAT(2)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(64), .READ_LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Present one request on u0 for exactly one acceptance edge.
    task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Full transaction on u0 with rsp_ready high; returns latency and payload.
    task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output int lat, output int low,
                            output logic [31:0] rd, output logic er);
        lat = 99;
        low = 0;
        rd  = 32'hFFFF_FFFF;
        er  = 1'bx;
        rsp_ready = 1'b1;
        start_req(w, a, d);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!req_ready) low++;
            if (rsp_valid) begin
                lat = i;
                rd  = rsp_rdata;
                er  = rsp_err;
                break;
            end
        end
        if (lat != 99) begin
            @(posedge clk);
            #1;
        end
        $display("txn %s addr=%h wdata=%h -> lat=%0d rdata=%h err=%b",
                 w ? "ST" : "LD", a, d, lat, rd, er);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; rsp_ready = 1;
        req_valid1 = 0; req_write1 = 0; req_addr1 = 0; req_wdata1 = 0; rsp_ready1 = 1;
        #3;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_u0: got ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        n_checks++;
        if (req_ready1 !== 1'b1 || rsp_valid1 !== 1'b0 || rsp_rdata1 !== 32'd0 || rsp_err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_u1: got ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                     req_ready1, rsp_valid1, rsp_rdata1, rsp_err1);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_load;
        int lat, low;
        logic [31:0] rd;
        logic er;
        transact(1'b1, 32'h10, 32'hDEADBEEF, lat, low, rd, er);
        n_checks++;
        if (lat !== 2 || low !== 2 || rd !== 32'd0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL store_0x10: got lat=%0d low=%0d rdata=%h err=%b, want 2 2 00000000 0", lat, low, rd, er);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_consume: got ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
        end
        transact(1'b0, 32'h10, 32'h0, lat, low, rd, er);
        n_checks++;
        if (lat !== 2 || low !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL load_0x10: got lat=%0d low=%0d rdata=%h err=%b, want 2 2 deadbeef 0", lat, low, rd, er);
        end
    endtask

    task automatic test_backpressure;
        int lat, low, got;
        logic [31:0] rd;
        logic er;
        transact(1'b1, 32'h0, 32'h0000_1111, lat, low, rd, er);
        transact(1'b1, 32'h4, 32'h0000_4444, lat, low, rd, er);
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        @(posedge clk);
        // keep req_valid high with a store that must be ignored while busy
        #1 req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'hBAD0BAD0;
        got = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = i;
                break;
            end
        end
        n_checks++;
        if (got !== 2) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d cycles, want 2", got);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_1111 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b, want 1 00001111 0 0",
                         k, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
        end
        transact(1'b0, 32'h4, 32'h0, lat, low, rd, er);
        n_checks++;
        if (rd !== 32'h0000_4444 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ignored_store: got rdata=%h err=%b, want 00004444 0", rd, er);
        end
    endtask

    task automatic test_errors;
        int lat, low;
        logic [31:0] rd;
        logic er;
        transact(1'b0, 32'h13, 32'h0, lat, low, rd, er);
        n_checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL err_load_0x13: got rdata=%h err=%b, want 00000000 1", rd, er);
        end
        transact(1'b1, 32'h100, 32'h1, lat, low, rd, er);
        n_checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL err_store_0x100: got rdata=%h err=%b, want 00000000 1", rd, er);
        end
        transact(1'b0, 32'h0, 32'h0, lat, low, rd, er);
        n_checks++;
        if (rd !== 32'h0000_1111 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_alias_range: got rdata=%h err=%b, want 00001111 0", rd, er);
        end
        transact(1'b1, 32'h2, 32'h2222, lat, low, rd, er);
        n_checks++;
        if (er !== 1'b1) begin
            n_fail++;
            $display("FAIL err_store_misaligned: got err=%b, want 1", er);
        end
        transact(1'b0, 32'h0, 32'h0, lat, low, rd, er);
        n_checks++;
        if (rd !== 32'h0000_1111 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_alias_misaligned: got rdata=%h err=%b, want 00001111 0", rd, er);
        end
    endtask

    task automatic test_boundary;
        int lat, low;
        logic [31:0] rd;
        logic er;
        transact(1'b1, 32'hFC, 32'hA5A5_5A5A, lat, low, rd, er);
        n_checks++;
        if (er !== 1'b0) begin
            n_fail++;
            $display("FAIL bound_store_0xfc: got err=%b, want 0", er);
        end
        transact(1'b0, 32'hFC, 32'h0, lat, low, rd, er);
        n_checks++;
        if (rd !== 32'hA5A5_5A5A || er !== 1'b0) begin
            n_fail++;
            $display("FAIL bound_load_0xfc: got rdata=%h err=%b, want a5a55a5a 0", rd, er);
        end
        transact(1'b0, 32'h100, 32'h0, lat, low, rd, er);
        n_checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL bound_load_0x100: got rdata=%h err=%b, want 00000000 1", rd, er);
        end
        transact(1'b0, 32'hFFFF_FFFC, 32'h0, lat, low, rd, er);
        n_checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL bound_load_high: got rdata=%h err=%b, want 00000000 1", rd, er);
        end
    endtask

    task automatic test_lat1;
        rsp_ready1 = 1'b1;
        @(negedge clk);
        req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 32'h8; req_wdata1 = 32'h0000_55AA;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid1 !== 1'b1 || req_ready1 !== 1'b0 || rsp_err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat1_store: got valid=%b ready=%b err=%b, want 1 0 0", rsp_valid1, req_ready1, rsp_err1);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (req_ready1 !== 1'b1 || rsp_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat1_idle: got ready=%b valid=%b, want 1 0", req_ready1, rsp_valid1);
        end
        req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 32'h8;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid1 !== 1'b1 || rsp_rdata1 !== 32'h0000_55AA || rsp_err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat1_load: got valid=%b rdata=%h err=%b, want 1 000055aa 0", rsp_valid1, rsp_rdata1, rsp_err1);
        end
        $display("txn u1 ST/LD addr=00000008 -> rdata=%h", rsp_rdata1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int lat, low;
        logic [31:0] rd;
        logic er;
        rsp_ready = 1'b1;
        start_req(1'b1, 32'h24, 32'hCAFE_F00D);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait_state: got valid=%b ready=%b, want 0 0", rsp_valid, req_ready);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL no_rsp_after_reset[%0d]: got valid=%b, want 0", k, rsp_valid);
            end
        end
        // a load in flight must not leak its snapshot through a reset
        start_req(1'b0, 32'h10, 32'h0);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_rdata !== 32'd0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clears_rdata: got rdata=%h valid=%b err=%b, want 00000000 0 0", rsp_rdata, rsp_valid, rsp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        transact(1'b0, 32'h24, 32'h0, lat, low, rd, er);
        n_checks++;
        if (lat !== 2 || rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            n_fail++;
            $display("FAIL store_survives_reset: got lat=%0d rdata=%h err=%b, want 2 cafef00d 0", lat, rd, er);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_store_load();
        test_backpressure();
        test_errors();
        test_boundary();
        test_lat1();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
